ahbslv_mem: RTL

//  AHB slave (responder) fronting a word-wide SRAM. It is the far end of the DMA master's AHB bus.

---
 rtl/ahbslv_mem_if.sv | 26 ++
 rtl/ahbslv_mem.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ahbslv_mem_if.sv
// AHB slave-side bus bundle for ahbslv_mem: address/data phase inputs and the response.
`timescale 1ns/1ps

interface ahbslv_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahbslv_mem.sv
// AHB slave fronting a 32-bit word SRAM: pipelined single/burst beats, programmable
// wait states and a two-cycle ERROR response for out-of-window, oversize or misaligned beats.
`timescale 1ns/1ps

module ahbslv_mem #(
    parameter int unsigned AW        = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WAIT_ST   = 0
) (
    input logic         I_AHBS_HCLK,
    input logic         I_AHBS_RESET,
    ahbslv_mem_if.slave bus
);
    localparam int unsigned Depth = 2 ** AW;
    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespError = 2'b01;

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e        state_q;
    logic [2:0]    wcnt_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic          write_q;
    logic [31:0]   hrdata_q;
    logic          hreadyout_q;
    logic [1:0]    hresp_q;
    logic [31:0]   mem_q [Depth];

    logic [31:0]   offset;
    logic          in_range;
    logic          size_bad;
    logic          misaligned;
    logic          addr_err;
    logic          can_accept;
    logic          accept;
    logic          wr_done;
    logic [AW-1:0] a_word;
    logic [3:0]    a_be;
    logic [31:0]   rd_word;
    logic          unused_bus;

    // Address-phase decode
    assign offset     = bus.haddr - BASE_ADDR;
    assign in_range   = (bus.haddr >= BASE_ADDR) && ((offset >> (AW + 2)) == 32'd0);
    assign size_bad   = bus.hsize > 3'b010;
    assign misaligned = ((bus.hsize == 3'b001) && bus.haddr[0]) ||
                        ((bus.hsize == 3'b010) && (bus.haddr[1:0] != 2'b00));
    assign addr_err   = !in_range || size_bad || misaligned;
    // Only states that drive HREADYOUT=1 can take the next address phase
    assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept     = can_accept && bus.hsel && bus.hready && bus.htrans[1];
    assign a_word     = offset[AW+1:2];
    assign wr_done    = (state_q == StData) && write_q;
    // Burst type is informational; the address is taken from HADDR every beat
    assign unused_bus = ^bus.hburst;

    // Byte-lane enables from transfer size and low address bits (little-endian)
    always_comb begin
        a_be = 4'b1111;
        case (bus.hsize)
            3'b000:  a_be = 4'b0001 << bus.haddr[1:0];
            3'b001:  a_be = bus.haddr[1] ? 4'b1100 : 4'b0011;
            default: a_be = 4'b1111;
        endcase
    end

    // SRAM read with bypass of a write completing in the same cycle to the same word
    always_comb begin
        rd_word = mem_q[a_word];
        if (wr_done && (addr_q == a_word)) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) rd_word[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
        end
    end

    // SRAM array: byte-lane write on the completing DATA cycle; contents survive reset
    always_ff @(posedge I_AHBS_HCLK) begin
        if (wr_done && !I_AHBS_RESET) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[addr_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    // Response FSM with registered HREADYOUT/HRESP/HRDATA
    always_ff @(posedge I_AHBS_HCLK) begin
        if (I_AHBS_RESET) begin
            state_q     <= StIdle;
            wcnt_q      <= 3'd0;
            addr_q      <= '0;
            be_q        <= 4'd0;
            write_q     <= 1'b0;
            hrdata_q    <= 32'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RespOkay;
        end else begin
            case (state_q)
                StWait: begin
                    if (wcnt_q == 3'd0) begin
                        state_q     <= StData;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end
                end
                StErr1: begin
                    state_q     <= StErr2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RespError;
                end
                default: begin
                    // IDLE, DATA and ERR2: the pipelined address phase picks the next state
                    if (accept) begin
                        addr_q  <= a_word;
                        be_q    <= a_be;
                        write_q <= bus.hwrite && !addr_err;
                        if (addr_err) begin
                            state_q     <= StErr1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RespError;
                        end else begin
                            hresp_q <= RespOkay;
                            if (!bus.hwrite) hrdata_q <= rd_word;
                            if (WAIT_ST > 0) begin
                                state_q     <= StWait;
                                wcnt_q      <= 3'(WAIT_ST - 1);
                                hreadyout_q <= 1'b0;
                            end else begin
                                state_q     <= StData;
                                hreadyout_q <= 1'b1;
                            end
                        end
                    end else begin
                        state_q     <= StIdle;
                        write_q     <= 1'b0;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= RespOkay;
                    end
                end
            endcase
        end
    end

    assign bus.hrdata    = hrdata_q;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
endmodule
